// File: rtl/axi_xbar_pkg.sv
// axi_xbar_pkg: shared width helper, range decoder and error-sink index for the request router
package axi_xbar_pkg;
  localparam int MAX_M = 8;
  localparam int MAX_W = 64;
  function automatic int log2(input int x);
    int r = 1;
    while ((x >> r) != 0) r++;
    return r;
  endfunction
  function automatic int err_sink(input int num_master);
    return num_master;
  endfunction
  // lowest matching index wins; no match selects the error sink
  function automatic logic [3:0] addr_decode(input logic [MAX_W-1:0] addr, input logic [MAX_M*MAX_W-1:0] base,
                                             input logic [MAX_M*MAX_W-1:0] high, input int num_master);
    addr_decode = 4'(err_sink(num_master));
    for (int m = MAX_M - 1; m >= 0; m--)
      if (m < num_master && addr >= base[m*MAX_W +: MAX_W] && addr <= high[m*MAX_W +: MAX_W])
        addr_decode = 4'(m);
  endfunction
endpackage

// File: rtl/axi_interconnect_xbar_req_router_rr_arbiter.sv
// axi_interconnect_rr_arbiter: round-robin grant starting at ptr, ptr moves past the winner on advance
module axi_interconnect_rr_arbiter
  import axi_xbar_pkg::*;
#(
  parameter int N = 2,
  localparam int PW = log2(N - 1)
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] ptr
);
  logic [PW-1:0] win, nxt;
  always_comb begin
    gnt = '0;
    win = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % N] = 1'b1;
        win = PW'((int'(ptr) + k) % N);
      end
    nxt = (int'(win) == N - 1) ? '0 : win + 1'b1;
  end
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (advance) ptr <= nxt;
endmodule

// File: rtl/axi_interconnect_xbar_req_router.sv
// axi_interconnect_xbar_req_router: per-master round-robin request routing with per-slave ordering trackers
// Optional AXI_XBAR_DECERR_EN: unmatched requests are accepted locally and flagged on s_decerr.
module axi_interconnect_xbar_req_router
  import axi_xbar_pkg::*;
#(
  parameter int NUM_SLAVE = 2,
  parameter int NUM_MASTER = 2,
  parameter int WIDTH_ADDR = 32,
  parameter int WIDTH_ADDRINFO = 64,
  parameter int ADDR_LSB = 0,
  parameter logic [NUM_MASTER*WIDTH_ADDR-1:0] ADDR_BASE = '0,
  parameter logic [NUM_MASTER*WIDTH_ADDR-1:0] ADDR_HIGH = '0,
  parameter int NUM_OUTSTANDING = 4,
  parameter int WIDTH_SLAVE = log2(NUM_SLAVE - 1)
) (
  input  logic                                 clk_sys,
  input  logic                                 rst_n,
  input  logic [NUM_SLAVE*WIDTH_ADDRINFO-1:0]  s_addr_info,
  input  logic [NUM_SLAVE-1:0]                 s_addr_valid,
  output logic [NUM_SLAVE-1:0]                 s_addr_ready,
  input  logic [NUM_SLAVE-1:0]                 s_resp_done,
`ifdef AXI_XBAR_DECERR_EN
  output logic [NUM_SLAVE-1:0]                 s_decerr,
`endif
  output logic [NUM_MASTER*WIDTH_ADDRINFO-1:0] m_addr_info,
  output logic [NUM_MASTER*WIDTH_SLAVE-1:0]    m_addr_sid,
  output logic [NUM_MASTER-1:0]                m_addr_valid,
  input  logic [NUM_MASTER-1:0]                m_addr_ready
);
  localparam int DW = log2(NUM_MASTER);
  localparam int CW = $clog2(NUM_OUTSTANDING + 1);
  logic [MAX_M*MAX_W-1:0] base_x, high_x;
  logic [DW-1:0] tgt [NUM_SLAVE];
  logic [DW-1:0] dest_q [NUM_SLAVE];
  logic [CW-1:0] cnt_q [NUM_SLAVE];
  logic [NUM_SLAVE-1:0] elig, err_acc;
  logic [NUM_SLAVE-1:0] req [NUM_MASTER];
  logic [NUM_SLAVE-1:0] gnt [NUM_MASTER];
  logic [NUM_MASTER-1:0] load, valid_q;
  logic [WIDTH_ADDRINFO-1:0] info_q [NUM_MASTER];
  logic [WIDTH_ADDRINFO-1:0] sel_info [NUM_MASTER];
  logic [WIDTH_SLAVE-1:0] sid_q [NUM_MASTER];
  logic [WIDTH_SLAVE-1:0] sel_sid [NUM_MASTER];
  always_comb begin
    base_x = '0;
    high_x = '0;
    for (int m = 0; m < NUM_MASTER; m++) begin
      base_x[m*MAX_W +: MAX_W] = MAX_W'(ADDR_BASE[m*WIDTH_ADDR +: WIDTH_ADDR]);
      high_x[m*MAX_W +: MAX_W] = MAX_W'(ADDR_HIGH[m*WIDTH_ADDR +: WIDTH_ADDR]);
    end
  end
  // a slave with traffic in flight may only keep talking to the same destination
  always_comb begin
    for (int i = 0; i < NUM_SLAVE; i++) begin
      tgt[i] = DW'(addr_decode(MAX_W'(s_addr_info[i*WIDTH_ADDRINFO + ADDR_LSB +: WIDTH_ADDR]), base_x, high_x, NUM_MASTER));
      elig[i] = cnt_q[i] == '0 || (dest_q[i] == tgt[i] && cnt_q[i] < CW'(NUM_OUTSTANDING));
`ifdef AXI_XBAR_DECERR_EN
      err_acc[i] = s_addr_valid[i] && elig[i] && tgt[i] == DW'(err_sink(NUM_MASTER));
`else
      err_acc[i] = 1'b0;
`endif
    end
    for (int m = 0; m < NUM_MASTER; m++) begin
      load[m] = !valid_q[m] || m_addr_ready[m];
      for (int i = 0; i < NUM_SLAVE; i++)
        req[m][i] = s_addr_valid[i] && elig[i] && tgt[i] == DW'(m);
    end
  end
  for (genvar m = 0; m < NUM_MASTER; m++) begin : g_arb
    axi_interconnect_rr_arbiter #(.N(NUM_SLAVE)) u_arb (
      .clk_sys(clk_sys), .rst_n(rst_n), .req(req[m]), .advance(load[m] && |req[m]), .gnt(gnt[m]), .ptr()
    );
    assign m_addr_info[m*WIDTH_ADDRINFO +: WIDTH_ADDRINFO] = info_q[m];
    assign m_addr_sid[m*WIDTH_SLAVE +: WIDTH_SLAVE] = sid_q[m];
  end
  always_comb begin
    s_addr_ready = err_acc;
    for (int m = 0; m < NUM_MASTER; m++) begin
      sel_info[m] = '0;
      sel_sid[m] = '0;
      for (int i = 0; i < NUM_SLAVE; i++) begin
        s_addr_ready[i] = s_addr_ready[i] | (gnt[m][i] & load[m]);
        if (gnt[m][i]) begin
          sel_info[m] = s_addr_info[i*WIDTH_ADDRINFO +: WIDTH_ADDRINFO];
          sel_sid[m] = WIDTH_SLAVE'(i);
        end
      end
    end
  end
`ifdef AXI_XBAR_DECERR_EN
  assign s_decerr = err_acc;
`endif
  assign m_addr_valid = valid_q;
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_SLAVE; i++) begin
        cnt_q[i] <= '0;
        dest_q[i] <= '0;
      end
      for (int m = 0; m < NUM_MASTER; m++) begin
        info_q[m] <= '0;
        sid_q[m] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SLAVE; i++) begin
        cnt_q[i] <= cnt_q[i] + CW'(s_addr_ready[i]) - CW'(s_resp_done[i] && cnt_q[i] != '0);
        if (s_addr_ready[i]) dest_q[i] <= tgt[i];
      end
      for (int m = 0; m < NUM_MASTER; m++)
        if (load[m]) begin
          valid_q[m] <= |req[m];
          if (|req[m]) begin
            info_q[m] <= sel_info[m];
            sid_q[m] <= sel_sid[m];
          end
        end
    end
endmodule

// File: tb/tb_axi_interconnect_xbar_req_router.sv
// tb_axi_interconnect_xbar_req_router: directed scenarios plus randomized traffic against a reference model
module tb_axi_interconnect_xbar_req_router;
  logic clk_sys = 1'b0;
  logic rst_n = 1'b0;
  logic [127:0] s_addr_info = '0;
  logic [1:0] s_addr_valid = '0, s_resp_done = '0, m_addr_ready = '0;
  logic [1:0] s_addr_ready, m_addr_valid, m_addr_sid;
  logic [127:0] m_addr_info;
`ifdef AXI_XBAR_DECERR_EN
  logic [1:0] s_decerr;
`endif
  int tests = 0, errors = 0;
  always #5 clk_sys = ~clk_sys;
  axi_interconnect_xbar_req_router #(
    .NUM_SLAVE(2), .NUM_MASTER(2), .WIDTH_ADDR(32), .WIDTH_ADDRINFO(64), .ADDR_LSB(0),
    .ADDR_BASE({32'h1000_0000, 32'h0000_0000}), .ADDR_HIGH({32'h1FFF_FFFF, 32'h0FFF_FFFF}),
    .NUM_OUTSTANDING(4)
  ) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .s_addr_info(s_addr_info), .s_addr_valid(s_addr_valid),
    .s_addr_ready(s_addr_ready), .s_resp_done(s_resp_done),
`ifdef AXI_XBAR_DECERR_EN
    .s_decerr(s_decerr),
`endif
    .m_addr_info(m_addr_info), .m_addr_sid(m_addr_sid), .m_addr_valid(m_addr_valid), .m_addr_ready(m_addr_ready)
  );
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    s_addr_valid = '0;
    s_resp_done = '0;
    m_addr_ready = '0;
    s_addr_info = '0;
    repeat (2) @(posedge clk_sys);
    #1;
    rst_n = 1'b1;
  endtask
  task automatic set_req(input int i, input logic [31:0] a);
    s_addr_valid[i] = 1'b1;
    s_addr_info[i*64 +: 64] = {32'($urandom()), a};
  endtask
  function automatic int decode(input logic [31:0] a);
    if (a <= 32'h0FFF_FFFF) return 0;
    if (a >= 32'h1000_0000 && a <= 32'h1FFF_FFFF) return 1;
    return 2;
  endfunction
  task automatic test_reset();
    repeat (2) @(posedge clk_sys);
    #1;
    tests++; if (m_addr_valid !== 2'b00) begin errors++; $display("FAIL reset_valid got %b want 00", m_addr_valid); end
    tests++; if (m_addr_info !== '0) begin errors++; $display("FAIL reset_info got %h want 0", m_addr_info); end
    tests++; if (m_addr_sid !== 2'b00) begin errors++; $display("FAIL reset_sid got %b want 00", m_addr_sid); end
    tests++; if (s_addr_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", s_addr_ready); end
`ifdef AXI_XBAR_DECERR_EN
    tests++; if (s_decerr !== 2'b00) begin errors++; $display("FAIL reset_decerr got %b want 00", s_decerr); end
`endif
  endtask
  task automatic test_parallel();
    logic [63:0] p0, p1;
    do_reset();
    tick();
    set_req(0, 32'h0000_0100);
    set_req(1, 32'h1000_0200);
    p0 = s_addr_info[63:0];
    p1 = s_addr_info[127:64];
    #1;
    tests++; if (s_addr_ready !== 2'b11) begin errors++; $display("FAIL par_ready got %b want 11", s_addr_ready); end
    tick();
    s_addr_valid = '0;
    #1;
    tests++; if (m_addr_valid !== 2'b11) begin errors++; $display("FAIL par_valid got %b want 11", m_addr_valid); end
    tests++; if (m_addr_sid !== 2'b10) begin errors++; $display("FAIL par_sid got %b want 10", m_addr_sid); end
    tests++; if (m_addr_info[63:0] !== p0) begin errors++; $display("FAIL par_info0 got %h want %h", m_addr_info[63:0], p0); end
    tests++; if (m_addr_info[127:64] !== p1) begin errors++; $display("FAIL par_info1 got %h want %h", m_addr_info[127:64], p1); end
  endtask
  task automatic test_round_robin();
    logic [1:0] exp;
    do_reset();
    m_addr_ready = 2'b11;
    s_resp_done = 2'b11;
    for (int k = 0; k < 6; k++) begin
      tick();
      set_req(0, 32'h100 + 32'(k));
      set_req(1, 32'h200 + 32'(k));
      #1;
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
      tests++; if (s_addr_ready !== exp) begin errors++; $display("FAIL rr_ready[%0d] got %b want %b", k, s_addr_ready, exp); end
      if (k > 0) begin
        tests++;
        if (m_addr_valid[0] !== 1'b1 || m_addr_sid[0] !== 1'((k - 1) % 2)) begin
          errors++; $display("FAIL rr_sid[%0d] got v=%b sid=%b want v=1 sid=%0d", k, m_addr_valid[0], m_addr_sid[0], (k - 1) % 2);
        end
      end
    end
  endtask
  task automatic test_ordering_stall();
    do_reset();
    m_addr_ready = 2'b11;
    tick();
    set_req(0, 32'h0000_0010);
    #1;
    tests++; if (s_addr_ready[0] !== 1'b1) begin errors++; $display("FAIL ord_first got %b want 1", s_addr_ready[0]); end
    for (int k = 0; k < 3; k++) begin
      tick();
      set_req(0, 32'h1000_0000);
      #1;
      tests++; if (s_addr_ready[0] !== 1'b0) begin errors++; $display("FAIL ord_stall[%0d] got %b want 0", k, s_addr_ready[0]); end
    end
    tick();
    s_resp_done[0] = 1'b1;
    #1;
    tests++; if (s_addr_ready[0] !== 1'b0) begin errors++; $display("FAIL ord_done_cycle got %b want 0", s_addr_ready[0]); end
    tick();
    s_resp_done[0] = 1'b0;
    #1;
    tests++; if (s_addr_ready[0] !== 1'b1) begin errors++; $display("FAIL ord_release got %b want 1", s_addr_ready[0]); end
    tick();
    s_addr_valid = '0;
  endtask
  task automatic test_outstanding();
    logic [10:0] dp, ep;
    dp = 11'b00110100000;
    ep = 11'b01101001111;
    do_reset();
    m_addr_ready = 2'b01;
    for (int k = 0; k < 11; k++) begin
      tick();
      set_req(0, 32'h0000_1000 + 32'(k));
      s_resp_done[0] = dp[k];
      #1;
      tests++; if (s_addr_ready[0] !== ep[k]) begin errors++; $display("FAIL ost_ready[%0d] got %b want %b", k, s_addr_ready[0], ep[k]); end
    end
    tick();
    s_addr_valid = '0;
    s_resp_done = '0;
  endtask
  task automatic test_backpressure();
    logic [63:0] p1, p2;
    do_reset();
    tick();
    set_req(0, 32'h0000_2000);
    p1 = s_addr_info[63:0];
    #1;
    tests++; if (s_addr_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_first got %b want 1", s_addr_ready[0]); end
    tick();
    set_req(0, 32'h0000_3000);
    p2 = s_addr_info[63:0];
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if (m_addr_valid[0] !== 1'b1 || m_addr_info[63:0] !== p1 || s_addr_ready[0] !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b info=%h rdy=%b want v=1 info=%h rdy=0", k, m_addr_valid[0], m_addr_info[63:0], s_addr_ready[0], p1);
      end
      tick();
    end
    m_addr_ready[0] = 1'b1;
    #1;
    tests++; if (s_addr_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_ready got %b want 1", s_addr_ready[0]); end
    tick();
    s_addr_valid = '0;
    #1;
    tests++; if (m_addr_valid[0] !== 1'b1 || m_addr_info[63:0] !== p2) begin
      errors++; $display("FAIL bp_next got v=%b info=%h want v=1 info=%h", m_addr_valid[0], m_addr_info[63:0], p2);
    end
  endtask
  task automatic test_decerr();
    do_reset();
    m_addr_ready = 2'b11;
    tick();
    set_req(0, 32'h2000_0000);
    #1;
`ifdef AXI_XBAR_DECERR_EN
    tests++; if (s_addr_ready !== 2'b01) begin errors++; $display("FAIL dec_ready got %b want 01", s_addr_ready); end
    tests++; if (s_decerr !== 2'b01) begin errors++; $display("FAIL dec_pulse got %b want 01", s_decerr); end
    tick();
    s_addr_valid = '0;
    #1;
    tests++; if (s_decerr !== 2'b00) begin errors++; $display("FAIL dec_after got %b want 00", s_decerr); end
    tests++; if (m_addr_valid !== 2'b00) begin errors++; $display("FAIL dec_mvalid got %b want 00", m_addr_valid); end
`else
    for (int k = 0; k < 100; k++) begin
      tests++; if (s_addr_ready !== 2'b00) begin errors++; $display("FAIL dec_blocked[%0d] got %b want 00", k, s_addr_ready); end
      tick();
    end
    tests++; if (m_addr_valid !== 2'b00) begin errors++; $display("FAIL dec_mvalid got %b want 00", m_addr_valid); end
    s_addr_valid = '0;
`endif
  endtask
  task automatic test_random();
    int cnt[2], dst[2], ptr[2], msid[2], t[2], win[2];
    bit mv[2], el[2], ld[2];
    logic [63:0] minfo[2];
    logic [1:0] er, ed;
    logic [31:0] edges[4];
    logic [31:0] a;
    int r;
    edges = '{32'h0FFF_FFFF, 32'h1000_0000, 32'h1FFF_FFFF, 32'h2000_0000};
    do_reset();
    for (int i = 0; i < 2; i++) begin
      cnt[i] = 0; dst[i] = 0; ptr[i] = 0; mv[i] = 0; minfo[i] = '0; msid[i] = 0;
    end
    for (int c = 0; c < 2500; c++) begin
      tick();
      if (c == 1200) begin
        rst_n = 1'b0;
        #1;
        tests++; if (m_addr_valid !== 2'b00 || m_addr_info !== '0 || m_addr_sid !== 2'b00) begin
          errors++; $display("FAIL mid_reset got v=%b sid=%b info=%h want all 0", m_addr_valid, m_addr_sid, m_addr_info);
        end
        for (int i = 0; i < 2; i++) begin
          cnt[i] = 0; dst[i] = 0; ptr[i] = 0; mv[i] = 0; minfo[i] = '0; msid[i] = 0;
        end
        tick();
        rst_n = 1'b1;
      end
      for (int i = 0; i < 2; i++) begin
        r = $urandom_range(0, 11);
        a = r < 5 ? $urandom_range(0, 32'h0FFF_FFFF) : r < 9 ? 32'h1000_0000 + $urandom_range(0, 32'h0FFF_FFFF) :
            r < 11 ? edges[$urandom_range(0, 3)] : (32'h2000_0000 | ($urandom() & 32'h0FFF_FFFF));
        set_req(i, a);
        s_addr_valid[i] = ($urandom_range(0, 3) != 0);
        s_resp_done[i] = ($urandom_range(0, 2) == 0);
      end
      m_addr_ready = 2'($urandom());
      #1;
      er = '0;
      ed = '0;
      for (int i = 0; i < 2; i++) begin
        t[i] = decode(s_addr_info[i*64 +: 32]);
        el[i] = cnt[i] == 0 || (dst[i] == t[i] && cnt[i] < 4);
      end
      for (int m = 0; m < 2; m++) begin
        ld[m] = !mv[m] || m_addr_ready[m];
        win[m] = -1;
        for (int k = 0; k < 2; k++)
          if (win[m] < 0 && s_addr_valid[(ptr[m] + k) % 2] && el[(ptr[m] + k) % 2] && t[(ptr[m] + k) % 2] == m)
            win[m] = (ptr[m] + k) % 2;
        if (ld[m] && win[m] >= 0) er[win[m]] = 1'b1;
      end
`ifdef AXI_XBAR_DECERR_EN
      for (int i = 0; i < 2; i++)
        if (s_addr_valid[i] && el[i] && t[i] == 2) begin er[i] = 1'b1; ed[i] = 1'b1; end
      tests++; if (s_decerr !== ed) begin errors++; $display("FAIL rnd_decerr[%0d] got %b want %b", c, s_decerr, ed); end
`endif
      tests++; if (s_addr_ready !== er) begin errors++; $display("FAIL rnd_ready[%0d] got %b want %b", c, s_addr_ready, er); end
      tests++; if (m_addr_valid !== {mv[1], mv[0]}) begin errors++; $display("FAIL rnd_valid[%0d] got %b want %b", c, m_addr_valid, {mv[1], mv[0]}); end
      for (int m = 0; m < 2; m++)
        if (mv[m]) begin
          tests++;
          if (m_addr_info[m*64 +: 64] !== minfo[m] || m_addr_sid[m] !== 1'(msid[m])) begin
            errors++; $display("FAIL rnd_payload[%0d] m%0d got info=%h sid=%b want info=%h sid=%0d", c, m, m_addr_info[m*64 +: 64], m_addr_sid[m], minfo[m], msid[m]);
          end
        end
      for (int m = 0; m < 2; m++)
        if (ld[m]) begin
          mv[m] = win[m] >= 0;
          if (win[m] >= 0) begin
            minfo[m] = s_addr_info[win[m]*64 +: 64];
            msid[m] = win[m];
            ptr[m] = (win[m] + 1) % 2;
          end
        end
      for (int i = 0; i < 2; i++) begin
        cnt[i] = cnt[i] + int'(er[i]) - int'(s_resp_done[i] && cnt[i] > 0);
        if (er[i]) dst[i] = t[i];
      end
    end
    s_addr_valid = '0;
    s_resp_done = '0;
  endtask
  initial begin
    test_reset();
    test_parallel();
    test_round_robin();
    test_ordering_stall();
    test_outstanding();
    test_backpressure();
    test_decerr();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
